// File: rtl/sentinel_key_presenter_if.sv
// Handshake and lock-facing signal bundle for the Sentinel key presenter.
// master: controller plus lock side; slave: the presenter itself.
interface sentinel_key_presenter_if;
    logic       start;
    logic       abort;
    logic [7:0] key_out;
    logic [7:0] seg_in;
    logic [7:0] glow_in;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [1:0] attempts;

    modport master (
        output start, abort, seg_in, glow_in,
        input  key_out, busy, done, result, attempts
    );

    modport slave (
        input  start, abort, seg_in, glow_in,
        output key_out, busy, done, result, attempts
    );
endinterface

// File: rtl/sentinel_key_presenter.sv
// Initiator for the Sentinel lock: presents the key, samples the lock's display and glow,
// releases the key, checks the lock relocked, and posts GRANTED/DENIED/FAULT with retries.
module sentinel_key_presenter #(
    parameter logic [7:0]  KEY           = 8'hB6,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter logic [7:0]  SEG_VERIFIED  = 8'hC1,
    parameter logic [7:0]  SEG_LOCKED    = 8'hC7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sentinel_key_presenter_if.slave  bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ATT_W = 2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_RETRIES);

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_GRANTED = 2'b01;
    localparam logic [1:0] RES_DENIED  = 2'b10;
    localparam logic [1:0] RES_FAULT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [1:0]         pend_q,     pend_d;
    logic [7:0]         key_q,      key_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [1:0]         result_q,   result_d;
    logic [ATT_W-1:0]   attempts_q, attempts_d;

    logic               in_busy;
    logic               relocked;
    logic [1:0]         final_res;

    // Outputs are a registered image of the state occupied during the previous cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        result_d   = result_q;
        attempts_d = attempts_q;
        final_res  = pend_q;

        in_busy  = (state_q == ST_DRIVE)  || (state_q == ST_SETTLE) ||
                   (state_q == ST_SAMPLE) || (state_q == ST_RELEASE);
        relocked = (bus.seg_in == SEG_LOCKED) && (bus.glow_in == 8'h00);

        key_d  = ((state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                  (state_q == ST_SAMPLE)) ? KEY : 8'h00;
        busy_d = in_busy;
        done_d = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d    = ST_DRIVE;
                    result_d   = RES_NONE;
                    attempts_d = '0;
                end
            end
            ST_DRIVE: begin
                if (attempts_q < ATT_MAX) begin
                    attempts_d = attempts_q + ATT_W'(1);
                end
                cnt_d   = CNT_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if ((bus.seg_in == SEG_VERIFIED) && (bus.glow_in == 8'hFF)) begin
                    pend_d = RES_GRANTED;
                end else if (relocked) begin
                    pend_d = RES_DENIED;
                end else begin
                    pend_d = RES_FAULT;
                end
                cnt_d   = CNT_LOAD;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    // A lock that fails to relock after key release overrides any verdict.
                    final_res = relocked ? pend_q : RES_FAULT;
                    pend_d    = final_res;
                    if ((final_res == RES_DENIED) && (attempts_q < ATT_MAX)) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                result_d = pend_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.abort && in_busy) begin
            state_d    = ST_IDLE;
            result_d   = RES_NONE;
            attempts_d = attempts_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= RES_NONE;
            key_q      <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= RES_NONE;
            attempts_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            key_q      <= key_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            attempts_q <= attempts_d;
        end
    end

    assign bus.key_out  = key_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.attempts = attempts_q;

endmodule

// File: tb/tb_sentinel_key_presenter.sv
// Scoreboard bench for sentinel_key_presenter with a behavioural Sentinel lock model.
module tb_sentinel_key_presenter;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   mode;
    logic stuck;

    typedef struct {
        int         cyc;
        logic [1:0] res;
        logic [1:0] att;
    } exp_t;

    exp_t exp_q[$];

    sentinel_key_presenter_if bus();

    sentinel_key_presenter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Lock model. 0 accept B6, 1 always locked, 2 blank display, 3 partial glow, 4 stuck open.
    always @(posedge clk) begin
        if (mode != 4)                  stuck <= 1'b0;
        else if (bus.key_out == 8'hB6)  stuck <= 1'b1;
    end

    always_comb begin
        bus.seg_in  = 8'hC7;
        bus.glow_in = 8'h00;
        case (mode)
            0: if (bus.key_out == 8'hB6) begin bus.seg_in = 8'hC1; bus.glow_in = 8'hFF; end
            2: begin bus.seg_in = 8'hFF; bus.glow_in = 8'h00; end
            3: if (bus.key_out == 8'hB6) begin bus.seg_in = 8'hC1; bus.glow_in = 8'h7F; end
            4: if (bus.key_out == 8'hB6 || stuck) begin bus.seg_in = 8'hC1; bus.glow_in = 8'hFF; end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle",    32'(cyc),          32'(e.cyc));
                chk("done_result",   32'(bus.result),   32'(e.res));
                chk("done_attempts", 32'(bus.attempts), 32'(e.att));
            end
        end
    end

    task automatic run_seq(input int mode_i, input int n_att, input logic [1:0] res,
                           input int pulse_at);
        int t;
        int phase;
        mode = mode_i;
        @(negedge clk);
        bus.start = 1'b1;
        t = cyc + 1;
        exp_q.push_back('{t + 1 + n_att * 10, res, 2'(n_att)});
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= n_att * 10; k++) begin
            @(negedge clk);
            if (k == pulse_at - 1) bus.start = 1'b1;
            if (k == pulse_at)     bus.start = 1'b0;
            phase = (k - 1) % 10;
            chk("key_trace",  32'(bus.key_out), (phase < 6) ? 32'hB6 : 32'h00);
            chk("busy_trace", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        chk("busy_after_done", 32'(bus.busy),   32'd0);
        chk("result_posted",   32'(bus.result), 32'(res));
        @(negedge clk);
        chk("idle_done_low", 32'(bus.done),    32'd0);
        chk("idle_key_low",  32'(bus.key_out), 32'd0);
        chk("result_held",   32'(bus.result),  32'(res));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t;
        cyc = 0; checks = 0; errors = 0; mode = 0;
        rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_key",      32'(bus.key_out),  32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_result",   32'(bus.result),   32'd0);
        chk("rst_attempts", 32'(bus.attempts), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(0, 1, 2'b01, 0);  // granted
        run_seq(1, 3, 2'b10, 0);  // denied three times
        run_seq(2, 1, 2'b11, 0);  // blank display
        run_seq(3, 1, 2'b11, 0);  // partial glow
        run_seq(4, 1, 2'b11, 0);  // lock stuck open after release
        run_seq(0, 1, 2'b01, 3);  // start pulse mid-run ignored

        // Abort sampled at edge t+5.
        mode = 0;
        bus.start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_key_before", 32'(bus.key_out), 32'hB6);
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        chk("abort_edge", 32'(cyc), 32'(t + 5));
        @(negedge clk);
        chk("abort_key",      32'(bus.key_out),  32'd0);
        chk("abort_busy",     32'(bus.busy),     32'd0);
        chk("abort_result",   32'(bus.result),   32'd0);
        chk("abort_attempts", 32'(bus.attempts), 32'd1);
        repeat (20) @(negedge clk);
        chk("abort_no_done_result", 32'(bus.result), 32'd0);

        // Start together with abort in IDLE: abort wins.
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", 32'(bus.busy),    32'd0);
        chk("start_abort_key",  32'(bus.key_out), 32'd0);
        repeat (3) @(negedge clk);

        // Reset during SETTLE.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_attempts", 32'(bus.attempts), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_key",      32'(bus.key_out),  32'd0);
        chk("mid_rst_busy",     32'(bus.busy),     32'd0);
        chk("mid_rst_done",     32'(bus.done),     32'd0);
        chk("mid_rst_result",   32'(bus.result),   32'd0);
        chk("mid_rst_attempts", 32'(bus.attempts), 32'd0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_reset_idle_busy", 32'(bus.busy), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
